// File: rtl/mem_responder.sv
// Single-port word memory that completes one read or write per request after a
// fixed LATENCY, acknowledging with a one-cycle pulse; requests seen while busy are dropped.
module mem_responder #(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wr_data,
    input  logic        mem_rd_req,
    input  logic        mem_wr_req,
    output logic [31:0] mem_rd_data,
    output logic        mem_ack,
    output logic        mem_busy
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [3:0]  CNT_LOAD   = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH) * 33'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t        state_r, state_nxt_s;
    logic [3:0]    cnt_r, cnt_nxt_s;
    logic [31:0]   addr_r, wdata_r;
    logic          is_wr_r;
    logic          accept_s, commit_s, in_range_s, op_wr_s;
    logic [31:0]   op_addr_s, op_wdata_s, rd_word_s;
    logic [AW-1:0] idx_s;
    logic [31:0]   mem_r [DEPTH];

    // Next-state and counter logic: accept in IDLE/ACK, count down in WAIT
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        accept_s    = 1'b0;
        case (state_r)
            ST_IDLE, ST_ACK: begin
                if (mem_rd_req || mem_wr_req) begin
                    accept_s = 1'b1;
                    if (LATENCY == 1) begin
                        state_nxt_s = ST_ACK;
                        cnt_nxt_s   = 4'd0;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        cnt_nxt_s   = CNT_LOAD;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = 4'd0;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = 4'd0;
            end
        endcase
    end

    // With LATENCY=1 the operation completes on the accepting edge, so it uses the live inputs
    always_comb begin
        if (state_r == ST_WAIT) begin
            op_addr_s  = addr_r;
            op_wdata_s = wdata_r;
            op_wr_s    = is_wr_r;
        end else begin
            op_addr_s  = mem_addr;
            op_wdata_s = mem_wr_data;
            op_wr_s    = mem_wr_req;
        end
    end

    assign commit_s   = (state_nxt_s == ST_ACK);
    assign in_range_s = ({1'b0, op_addr_s} < ADDR_LIMIT);
    assign idx_s      = op_addr_s[AW+1:2];
    assign rd_word_s  = mem_r[idx_s];

    // Control state, request latches and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 4'd0;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            is_wr_r     <= 1'b0;
            mem_ack     <= 1'b0;
            mem_busy    <= 1'b0;
            mem_rd_data <= 32'd0;
        end else begin
            state_r  <= state_nxt_s;
            cnt_r    <= cnt_nxt_s;
            mem_ack  <= commit_s;
            mem_busy <= (state_nxt_s == ST_WAIT);
            if (accept_s) begin
                addr_r  <= mem_addr;
                wdata_r <= mem_wr_data;
                is_wr_r <= mem_wr_req;
            end
            if (commit_s && !op_wr_s) begin
                mem_rd_data <= in_range_s ? rd_word_s : 32'd0;
            end
        end
    end

    // Storage is never cleared; writes are blocked while reset is asserted
    always_ff @(posedge clk) begin
        if (!rst && commit_s && op_wr_s && in_range_s) begin
            mem_r[idx_s] <= op_wdata_s;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder: two instances (LATENCY 4 and 1, DEPTH 16)
// share stimulus and are compared every cycle against a transaction-level model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wr_data = 32'd0;
    logic        mem_rd_req = 1'b0;
    logic        mem_wr_req = 1'b0;
    logic [31:0] rd_a, rd_b;
    logic        ack_a, ack_b, busy_a, busy_b;

    int n_checks = 0;
    int n_errors = 0;

    mem_responder #(.DEPTH(16), .LATENCY(4)) dut_a (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .mem_rd_data(rd_a), .mem_ack(ack_a), .mem_busy(busy_a));

    mem_responder #(.DEPTH(16), .LATENCY(1)) dut_b (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req),
        .mem_rd_data(rd_b), .mem_ack(ack_b), .mem_busy(busy_b));

    always #5 clk = ~clk;

    // Reference model: one outstanding transaction with a cycles-remaining count
    int          lat [2] = '{4, 1};
    bit          m_act [2];
    int          m_rem [2];
    bit          m_wr [2];
    logic [31:0] m_addr [2];
    logic [31:0] m_data [2];
    logic [31:0] m_mem [2][16];
    logic [31:0] m_rd [2];
    bit          m_ack [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_act[d] = 1'b0;
            m_rem[d] = 0;
            m_ack[d] = 1'b0;
            m_rd[d]  = 32'd0;
        end
    endtask

    task automatic model_complete(input int d);
        logic [31:0] a;
        a = m_addr[d];
        if (m_wr[d]) begin
            if (a < 32'd64) m_mem[d][a[5:2]] = m_data[d];
        end else begin
            m_rd[d] = (a < 32'd64) ? m_mem[d][a[5:2]] : 32'd0;
        end
        m_ack[d] = 1'b1;
    endtask

    task automatic model_edge(input int d);
        m_ack[d] = 1'b0;
        if (m_act[d]) begin
            m_rem[d]--;
            if (m_rem[d] == 0) begin
                m_act[d] = 1'b0;
                model_complete(d);
            end
        end else if (mem_rd_req || mem_wr_req) begin
            m_wr[d]   = mem_wr_req;
            m_addr[d] = mem_addr;
            m_data[d] = mem_wr_data;
            if (lat[d] == 1) begin
                model_complete(d);
            end else begin
                m_act[d] = 1'b1;
                m_rem[d] = lat[d] - 1;
            end
        end
    endtask

    task automatic compare();
        check_eq("ack_a",  {31'd0, ack_a},  {31'd0, m_ack[0]});
        check_eq("busy_a", {31'd0, busy_a}, {31'd0, m_act[0]});
        check_eq("rd_a",   rd_a,            m_rd[0]);
        check_eq("ack_b",  {31'd0, ack_b},  {31'd0, m_ack[1]});
        check_eq("busy_b", {31'd0, busy_b}, {31'd0, m_act[1]});
        check_eq("rd_b",   rd_b,            m_rd[1]);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        compare();
    endtask

    task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] dat);
        mem_rd_req  = rd;
        mem_wr_req  = wr;
        mem_addr    = a;
        mem_wr_data = dat;
    endtask

    task automatic drain();
        int n;
        drive(1'b0, 1'b0, mem_addr, mem_wr_data);
        n = 0;
        while ((busy_a || busy_b || ack_a || ack_b) && n < 20) begin
            step();
            n++;
        end
        check_eq("drain_timeout", {30'd0, busy_a, busy_b}, 32'd0);
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] dat);
        drive(rd, wr, a, dat);
        step();
        drain();
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        model_reset();
        compare();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)      return 32'($urandom_range(0, 63));
        else if (r < 9) return 32'($urandom_range(64, 127));
        else            return $urandom;
    endfunction

    initial begin
        int n;
        model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 16; i++) m_mem[d][i] = 32'h1000_0000 + 32'(i);
        #2;
        compare();
        step();
        rst = 1'b0;

        // Known contents for every word
        for (int i = 0; i < 16; i++) issue(1'b0, 1'b1, 32'(i * 4), 32'h1000_0000 + 32'(i));

        // Write, then read issued in the ack cycle
        drive(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        n = 0;
        while (!ack_a && n < 20) begin
            step();
            n++;
        end
        check_eq("r032_ack_seen", {31'd0, ack_a}, 32'd1);
        drive(1'b1, 1'b0, 32'h10, 32'h0);
        step();
        drain();
        check_eq("r032_rd", rd_a, 32'hDEAD_BEEF);

        // Alternating write/read every cycle
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive(1'b0, 1'b1, 32'h0, 32'd5);
            else            drive(1'b1, 1'b0, 32'h0, 32'h0);
            step();
        end
        drain();
        check_eq("r033_rd", rd_b, 32'd5);

        // Both requests high counts as a write
        issue(1'b1, 1'b1, 32'h20, 32'd7);
        check_eq("r035_rd_hold", rd_a, 32'hDEAD_BEEF);
        issue(1'b1, 1'b0, 32'h20, 32'h0);
        check_eq("r035_rd", rd_a, 32'd7);

        // Out-of-range accesses
        issue(1'b1, 1'b0, 32'h40, 32'h0);
        check_eq("r036_rd_oor", rd_a, 32'd0);
        issue(1'b0, 1'b1, 32'h40, 32'h0BAD);
        issue(1'b1, 1'b0, 32'h0, 32'h0);
        check_eq("r036_alias", rd_a, 32'd5);

        // Reset during WAIT aborts the write
        drive(1'b0, 1'b1, 32'h8, 32'd9);
        step();
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        pulse_rst();
        check_eq("r037_ack", {31'd0, ack_a}, 32'd0);
        drain();
        issue(1'b1, 1'b0, 32'h8, 32'h0);
        check_eq("r037_rd", rd_a, 32'h1000_0002);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                pulse_rst();
            end else begin
                drive(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), rand_addr(), $urandom);
                step();
            end
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DEPTH, 4096: storage size in 32-bit words; power of two.
REQ-002 Parameter LATENCY, 4: cycles from request acceptance to ack; legal range 1..15.
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 mem_addr  input  32  byte address from initiator, sampled on acceptance.
REQ-006 mem_wr_data  input  32  write data, sampled on acceptance.
REQ-007 mem_rd_req  input  1  read request, level-sampled at clk edge.
REQ-008 mem_wr_req  input  1  write request, level-sampled at clk edge.
REQ-009 mem_rd_data  output  32  registered read data.
REQ-010 mem_ack  output  1  single-cycle completion pulse for the accepted request.
REQ-011 mem_busy  output  1  high while a request is pending and not yet acked.

Function
REQ-012 States SHALL be IDLE, WAIT and ACK.
REQ-013 A request is accepted at an edge where state is IDLE or ACK and (mem_rd_req or mem_wr_req) is high; addr, wr_data and operation SHALL be latched at that edge.
REQ-014 Requests at edges where state is WAIT SHALL be ignored; no queuing.
REQ-015 mem_rd_req and mem_wr_req both high at acceptance SHALL be treated as a write only.
REQ-016 A request accepted at edge T SHALL produce mem_ack high for exactly the cycle following edge T+LATENCY-1, i.e. LATENCY cycles after acceptance.
REQ-017 LATENCY=1: accept at edge T -> state ACK directly after T; WAIT never entered.
REQ-018 LATENCY>1: accept -> WAIT with a 4-bit counter loaded to LATENCY-2; counter decrements each edge; at count 0 the next edge -> ACK.
REQ-019 From ACK: new request accepted -> per REQ-017/018; else -> IDLE; mem_ack SHALL never be high two consecutive cycles for one request.
REQ-020 mem_busy SHALL be high exactly while state is WAIT; low in IDLE and ACK, so back-to-back requests issued during the ack cycle are accepted.
REQ-021 Word index = mem_addr[log2(DEPTH)+1:2]; mem_addr[1:0] ignored.
REQ-022 Address in range iff mem_addr < DEPTH*4.
REQ-023 Read: on the edge entering ACK, mem_rd_data SHALL load storage[index], or 0 if out of range.
REQ-024 Write: storage[index] SHALL be updated on the edge entering ACK; out-of-range writes dropped; mem_rd_data unchanged by writes.
REQ-025 mem_rd_data SHALL hold its value until the next completed read.
REQ-026 A read completing one cycle after a write ack to the same address SHALL return the written data.
REQ-027 Ack and completion rules SHALL be identical for in-range and out-of-range requests.

Reset
REQ-028 rst high SHALL immediately force state IDLE, counter 0, mem_ack 0, mem_busy 0, mem_rd_data 0.
REQ-029 Storage contents SHALL NOT be cleared by reset.
REQ-030 Reset during WAIT SHALL abort the request: no ack after release; a pending write SHALL not be committed.
REQ-031 The first edge with rst low SHALL be able to accept a request.

Verification
REQ-032 LATENCY=4: write 0xDEADBEEF @0x10 at edge 0 -> busy high cycles 1-3, ack in cycle 4 only; read @0x10 issued in ack cycle -> ack 4 cycles later, rd_data=0xDEADBEEF.
REQ-033 LATENCY=1: alternating write @0x0=5, read @0x0 every cycle -> ack every cycle, busy never high, read returns 5.
REQ-034 rd_req held high through WAIT with changing addr -> only the first addr serviced; second request accepted in ack cycle.
REQ-035 Both req high, addr 0x20, data 7 -> write committed, rd_data unchanged; later read @0x20 returns 7.
REQ-036 DEPTH=16: read @0x40 -> ack at normal latency, rd_data=0; write @0x40 -> storage[0] unchanged.
REQ-037 Write @0x8=9 accepted, rst pulsed in WAIT -> outputs zero, no ack; subsequent read @0x8 returns prior contents, not 9.
